// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ps2_pkg
// Description : Shared types and constants for the PS/2 scancode receiver.
// Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

  // Frame-level receive state
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  // Prefix bytes that modify the following scancode rather than being codes
  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BREAK = 8'hF0;

endpackage
`default_nettype wire

// File: rtl/ps2_line_filter.sv
`default_nettype none
// ============================================================================
// Module      : ps2_line_filter
// Description : Two-flop synchronizer followed by a FILTER_LEN-sample
//               persistence filter; flags the filtered 1->0 transition.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_line_filter
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic resetn,
  input  logic raw_in,
  output logic filt_out,
  output logic fall_out
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;

  logic [1:0]    sync_q, sync_d;
  logic          filt_q, filt_d;
  logic          fall_q, fall_d;
  logic [CW-1:0] cnt_q,  cnt_d;

  // Count consecutive synchronized samples that disagree with the filtered
  // level; flip only once FILTER_LEN of them have been seen in a row.
  always_comb begin
    sync_d = {sync_q[0], raw_in};
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync_q[1] != filt_q) begin
      if (cnt_q == CW'(FILTER_LEN - 1)) begin
        filt_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    fall_d = filt_q & ~filt_d;
  end

  // State registers; bus idles high out of reset
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q <= 2'b11;
      filt_q <= 1'b1;
      fall_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      filt_q <= filt_d;
      fall_q <= fall_d;
      cnt_q  <= cnt_d;
    end
  end

  assign filt_out = filt_q;
  assign fall_out = fall_q;

endmodule
`default_nettype wire

// File: rtl/ps2_scancode_rx.sv
`default_nettype none
// ============================================================================
// Module      : ps2_scancode_rx
// Description : PS/2 keyboard receiver: frames bytes off the filtered clock,
//               checks parity/stop, folds E0/F0 prefixes into flags.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_scancode_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       code_break,
  output logic       code_ext,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic          clk_filt;
  logic          edge_fall;
  logic [1:0]    dsync_q, dsync_d;
  logic          bit_in;

  ps2_state_e    state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          ext_pend_q, ext_pend_d;
  logic          brk_pend_q, brk_pend_d;
  logic [7:0]    code_q, code_d;
  logic          code_valid_q, code_valid_d;
  logic          code_break_q, code_break_d;
  logic          code_ext_q, code_ext_d;
  logic          frame_err_q, frame_err_d;

  ps2_line_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_clk_filter (
    .clk      (clk),
    .resetn   (resetn),
    .raw_in   (ps2_clk),
    .filt_out (clk_filt),
    .fall_out (edge_fall)
  );

  assign bit_in = dsync_q[1];

  // Frame FSM, prefix tracking and inter-edge timeout
  always_comb begin
    dsync_d      = {dsync_q[0], ps2_data};
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_d        = par_q;
    ext_pend_d   = ext_pend_q;
    brk_pend_d   = brk_pend_q;
    code_d       = code_q;
    code_break_d = code_break_q;
    code_ext_d   = code_ext_q;
    code_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    tmo_d        = (tmo_q == TW'(TIMEOUT_CYCLES)) ? tmo_q : tmo_q + TW'(1);

    if (edge_fall) begin
      // An edge always wins over a coincident timeout
      tmo_d = '0;
      unique case (state_q)
        ST_IDLE: begin
          bit_cnt_d = 3'd0;
          if (!bit_in) state_d = ST_DATA;
        end
        ST_DATA: begin
          shift_d   = {bit_in, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
        end
        ST_PARITY: begin
          par_d   = bit_in;
          state_d = ST_STOP;
        end
        ST_STOP: begin
          state_d = ST_IDLE;
          if (bit_in && (^{shift_q, par_q})) begin
            if (shift_q == PS2_EXT) begin
              ext_pend_d = 1'b1;
            end else if (shift_q == PS2_BREAK) begin
              brk_pend_d = 1'b1;
            end else begin
              code_d       = shift_q;
              code_break_d = brk_pend_q;
              code_ext_d   = ext_pend_q;
              code_valid_d = 1'b1;
              ext_pend_d   = 1'b0;
              brk_pend_d   = 1'b0;
            end
          end else begin
            frame_err_d = 1'b1;
            ext_pend_d  = 1'b0;
            brk_pend_d  = 1'b0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q == ST_IDLE) begin
      tmo_d = '0;
    end else if (tmo_q >= TW'(TIMEOUT_CYCLES - 1)) begin
      // This cycle is the TIMEOUT_CYCLES-th without an edge: abandon frame
      state_d     = ST_IDLE;
      tmo_d       = '0;
      frame_err_d = 1'b1;
      ext_pend_d  = 1'b0;
      brk_pend_d  = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dsync_q      <= 2'b11;
      state_q      <= ST_IDLE;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'h00;
      par_q        <= 1'b0;
      tmo_q        <= '0;
      ext_pend_q   <= 1'b0;
      brk_pend_q   <= 1'b0;
      code_q       <= 8'h00;
      code_valid_q <= 1'b0;
      code_break_q <= 1'b0;
      code_ext_q   <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      dsync_q      <= dsync_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      tmo_q        <= tmo_d;
      ext_pend_q   <= ext_pend_d;
      brk_pend_q   <= brk_pend_d;
      code_q       <= code_d;
      code_valid_q <= code_valid_d;
      code_break_q <= code_break_d;
      code_ext_q   <= code_ext_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign code       = code_q;
  assign code_valid = code_valid_q;
  assign code_break = code_break_q;
  assign code_ext   = code_ext_q;
  assign frame_err  = frame_err_q;

  // Filtered clock level is only consumed through its falling-edge flag
  logic unused_ok;
  assign unused_ok = clk_filt;

endmodule
`default_nettype wire

// File: tb/tb_ps2_scancode_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_scancode_rx
// Description : Self-checking bench for ps2_scancode_rx with a frame-level
//               reference model and randomized keyboard traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_scancode_rx;

  localparam int FL  = 8;
  localparam int TMO = 400;

  logic       clk      = 1'b0;
  logic       resetn   = 1'b0;
  logic       ps2_clk  = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] code;
  logic       code_valid, code_break, code_ext, frame_err;

  ps2_scancode_rx #(
    .FILTER_LEN     (FL),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .code       (code),
    .code_valid (code_valid),
    .code_break (code_break),
    .code_ext   (code_ext),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // Pulse monitor on the falling clock edge
  int   n_valid = 0, n_err = 0, n_wide = 0;
  logic prev_v = 1'b0, prev_e = 1'b0;
  always @(negedge clk) begin
    if (resetn) begin
      if (code_valid) n_valid++;
      if (frame_err)  n_err++;
      if ((code_valid && prev_v) || (frame_err && prev_e)) n_wide++;
    end
    prev_v = code_valid;
    prev_e = frame_err;
  end

  // Reference model: frame-level keyboard protocol semantics
  int         exp_valid = 0, exp_err = 0;
  logic       m_ext = 1'b0, m_brk = 1'b0;
  logic [7:0] m_code = 8'h00;
  logic       m_cbrk = 1'b0, m_cext = 1'b0;

  task automatic model_frame(input logic [7:0] b, input bit ok);
    if (!ok) begin
      exp_err++;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
      exp_valid++;
      m_code = b;
      m_cbrk = m_brk;
      m_cext = m_ext;
      m_ext  = 1'b0;
      m_brk  = 1'b0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One PS/2 bit: data set while clock high, keyboard drives clock low then high.
  // With glitch set, FL-1 cycle spikes are injected in both clock phases.
  task automatic ps2_bit(input bit b, input bit glitch);
    ps2_data = b;
    cyc(10);
    if (glitch) begin
      ps2_clk = 1'b0; cyc(FL - 1);
      ps2_clk = 1'b1; cyc(6);
    end
    ps2_clk = 1'b0;
    cyc(16);
    if (glitch) begin
      ps2_clk = 1'b1; cyc(FL - 1);
      ps2_clk = 1'b0; cyc(6);
    end
    cyc(4);
    ps2_clk = 1'b1;
    cyc(6);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input bit glitch);
    ps2_bit(1'b0, glitch);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], glitch);
    ps2_bit((~^b) ^ bad_par, glitch);
    ps2_bit(~bad_stop, glitch);
    ps2_data = 1'b1;
    cyc(30);
    model_frame(b, !(bad_par || bad_stop));
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".valid_cnt"}, n_valid, exp_valid);
    chk({tag, ".err_cnt"},   n_err,   exp_err);
    chk({tag, ".code"},      code,    m_code);
    chk({tag, ".break"},     code_break, m_cbrk);
    chk({tag, ".ext"},       code_ext,   m_cext);
  endtask

  initial begin
    // Reset state
    #23;
    chk("rst.code",  code,       0);
    chk("rst.valid", code_valid, 0);
    chk("rst.break", code_break, 0);
    chk("rst.ext",   code_ext,   0);
    chk("rst.err",   frame_err,  0);
    cyc(2);
    resetn = 1'b1;
    cyc(20);

    // Plain make code
    send_frame(8'h1C, 0, 0, 0);
    check_outputs("make_1c");

    // Break prefix
    send_frame(8'hF0, 0, 0, 0);
    send_frame(8'h1C, 0, 0, 0);
    check_outputs("break_1c");

    // Extended break
    send_frame(8'hE0, 0, 0, 0);
    send_frame(8'hF0, 0, 0, 0);
    send_frame(8'h75, 0, 0, 0);
    check_outputs("ext_break_75");

    // Parity error, then recovery
    send_frame(8'hE0, 0, 0, 0);
    send_frame(8'h1C, 1, 0, 0);
    check_outputs("parity_err");
    send_frame(8'h1B, 0, 0, 0);
    check_outputs("after_parity");

    // Bad stop bit
    send_frame(8'h44, 0, 1, 0);
    check_outputs("stop_err");

    // Timeout after 4 data bits, with a break prefix pending
    send_frame(8'hF0, 0, 0, 0);
    ps2_bit(1'b0, 0);
    for (int i = 0; i < 4; i++) ps2_bit(i[0], 0);
    cyc(TMO - 60);
    chk("tmo.before", n_err, exp_err);
    cyc(100);
    exp_err++;
    m_ext = 1'b0;
    m_brk = 1'b0;
    chk("tmo.after", n_err, exp_err);
    send_frame(8'h23, 0, 0, 0);
    check_outputs("after_tmo");

    // Glitchy clock frame
    send_frame(8'h2B, 0, 0, 1);
    check_outputs("glitch_2b");

    // Reset mid-frame with an extended prefix pending
    send_frame(8'hE0, 0, 0, 0);
    ps2_bit(1'b0, 0);
    for (int i = 0; i < 3; i++) ps2_bit(1'b1, 0);
    ps2_data = 1'b0;
    cyc(10);
    ps2_clk = 1'b0;
    cyc(14);
    resetn = 1'b0;
    #2;
    chk("midrst.code",  code,       0);
    chk("midrst.valid", code_valid, 0);
    chk("midrst.break", code_break, 0);
    chk("midrst.ext",   code_ext,   0);
    chk("midrst.err",   frame_err,  0);
    cyc(5);
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    cyc(3);
    resetn = 1'b1;
    m_ext = 1'b0; m_brk = 1'b0; m_code = 8'h00; m_cbrk = 1'b0; m_cext = 1'b0;
    cyc(60);
    check_outputs("midrst.quiet");
    send_frame(8'h2B, 0, 0, 0);
    check_outputs("after_rst");

    // Randomized traffic
    for (int k = 0; k < 36; k++) begin
      logic [7:0] b;
      int sel;
      sel = $urandom_range(0, 9);
      b   = (sel == 0) ? 8'hE0 : (sel == 1) ? 8'hF0 : 8'($urandom_range(0, 255));
      send_frame(b, ($urandom_range(0, 9) == 0), ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 3) == 0));
      cyc($urandom_range(0, 40));
      check_outputs($sformatf("rnd%0d", k));
    end

    chk("pulse_width", n_wide, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
